// File: rtl/axi_7seg_mux.sv
// rtl/axi_7seg_mux.sv - AXI4-Lite controlled multiplexed seven-segment display driver
//
// Purpose:
//   Four AXI4-Lite registers select what a time-multiplexed common-anode or
//   common-cathode seven-segment display shows:
//     0x0 CTRL   bit0 EN (scan enable)
//     0x4 DIGITS nibble k is the hex value shown on digit k
//     0x8 DPMASK bit k lights the decimal point of digit k
//     0xC BRIGHT [3:0] PWM brightness (only with AXI7SEG_PWM_EN)
//   Bits beyond NUM_DIGITS, and unimplemented bits, read as zero and ignore writes.
//
// Optional feature macro:
//   AXI7SEG_PWM_EN - adds a free-running 4-bit PWM counter; a digit is lit only
//   while counter <= BRIGHT. Without it BRIGHT is fixed at 4'hF (reads 0xF,
//   writes ignored) and the selected digit is always lit.
//
// Ports:
//   ACLK, ARESETN            clock and asynchronous active-low reset
//   S_AXI_AW*/W*/B*          AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*             AXI4-Lite read address and data channels
//   seg_o[6:0]               segments {g,f,e,d,c,b,a}, registered
//   dp_o                     decimal point, registered
//   an_o[NUM_DIGITS-1:0]     one-hot digit enable, registered
//   All display outputs are active-low when ACTIVE_LOW=1.

module axi_7seg_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [3:0]            S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [3:0]            S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [NUM_DIGITS-1:0] an_o
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic INV = (ACTIVE_LOW != 0);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic                  ctrl_en;
    logic [DW-1:0]         digits;
    logic [NUM_DIGITS-1:0] dpmask;
    logic [3:0]            bright;
    logic                  pwm_on;

`ifdef AXI7SEG_PWM_EN
    logic [3:0] pwm_cnt;

    // Free-running; never gated by EN so duty cycle is independent of scanning.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign pwm_on = (pwm_cnt <= bright);
`else
    assign bright = 4'hF;
    assign pwm_on = 1'b1;
`endif

    // Zero-extended view of one register; shared by the read path and by
    // the write path for byte-strobe merging.
    function automatic logic [31:0] read_reg(
        input logic [1:0]            sel,
        input logic                  en,
        input logic [DW-1:0]         dig,
        input logic [NUM_DIGITS-1:0] dp,
        input logic [3:0]            br
    );
        logic [31:0] w;
        w = '0;
        case (sel)
            2'd0:    w[0]              = en;
            2'd1:    w[DW-1:0]         = dig;
            2'd2:    w[NUM_DIGITS-1:0] = dp;
            default: w[3:0]            = br;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    // AXI4-Lite handshakes
    // ------------------------------------------------------------------
    logic        wr_ready;
    logic        bvalid;
    logic        ar_ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        wr_fire;
    logic        rd_fire;
    logic [31:0] wr_new;
    logic [31:0] rd_word;

    assign S_AXI_AWREADY = wr_ready;
    assign S_AXI_WREADY  = wr_ready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = 2'b00;

    assign wr_fire = wr_ready & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire = ar_ready & S_AXI_ARVALID;

    always_comb begin
        wr_new = read_reg(S_AXI_AWADDR[3:2], ctrl_en, digits, dpmask, bright);
        for (int b = 0; b < 4; b++) begin
            if (S_AXI_WSTRB[b]) begin
                wr_new[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // Read data is sampled from the registers before this edge's write, so a
    // same-cycle read of the written register returns the pre-write value.
    assign rd_word = read_reg(S_AXI_ARADDR[3:2], ctrl_en, digits, dpmask, bright);

    // Byte-lane and register-select bits that carry no state of their own.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wr_new};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ready <= 1'b0;
            bvalid   <= 1'b0;
            ar_ready <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= 32'd0;
            ctrl_en  <= 1'b0;
            digits   <= '0;
            dpmask   <= '0;
`ifdef AXI7SEG_PWM_EN
            bright   <= 4'hF;
`endif
        end else begin
            // Ready is a single-cycle pulse; the !wr_ready term stops it from
            // re-arming in the handshake cycle itself.
            wr_ready <= ~wr_ready & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid;
            if (wr_fire) begin
                bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end

            ar_ready <= ~ar_ready & S_AXI_ARVALID & ~rvalid;
            if (rd_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
            end else if (S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end

            if (wr_fire) begin
                case (S_AXI_AWADDR[3:2])
                    2'd0: ctrl_en <= wr_new[0];
                    2'd1: digits  <= wr_new[DW-1:0];
                    2'd2: dpmask  <= wr_new[NUM_DIGITS-1:0];
`ifdef AXI7SEG_PWM_EN
                    default: bright <= wr_new[3:0];
`else
                    default: ;
`endif
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Refresh prescaler and digit index
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            presc <= '0;
            idx   <= '0;
        end else if (!ctrl_en) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Glyph decode and registered display outputs
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    logic [3:0]            nibble;
    logic                  dp_bit;
    logic                  lit;
    logic [NUM_DIGITS-1:0] onehot;

    // Compare-based mux keeps every selection in range even when NUM_DIGITS
    // is not a power of two.
    always_comb begin
        nibble = 4'd0;
        dp_bit = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nibble = digits[4*k +: 4];
                dp_bit = dpmask[k];
            end
        end
    end

    assign lit    = ctrl_en & pwm_on;
    assign onehot = NUM_DIGITS'(1) << idx;

    // Build active-high values, then flip once for the selected polarity.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            an_o  <= {NUM_DIGITS{INV}};
            seg_o <= {7{INV}};
            dp_o  <= INV;
        end else begin
            an_o  <= (lit ? onehot : '0) ^ {NUM_DIGITS{INV}};
            seg_o <= (lit ? hex_glyph(nibble) : 7'h00) ^ {7{INV}};
            dp_o  <= (lit & dp_bit) ^ INV;
        end
    end

endmodule
